// File: rtl/time_edit_pkg.sv
// Shared types and field-select encoding for the time edit controller and the hh:mm:ss counter.
package time_edit_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EDIT_HH = 2'd1,
    EDIT_MM = 2'd2,
    EDIT_SS = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_SS   = 2'b01;
  localparam logic [1:0] SEL_MM   = 2'b10;
  localparam logic [1:0] SEL_HH   = 2'b11;

  function automatic logic [1:0] state_sel(input state_t s);
    case (s)
      EDIT_HH: state_sel = SEL_HH;
      EDIT_MM: state_sel = SEL_MM;
      EDIT_SS: state_sel = SEL_SS;
      default: state_sel = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: 2-FF synchroniser, tick-based stability counter,
// debounced level and a 1-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      // Any sample matching the current level is a bounce and restarts the count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (tick_ms) begin
        if (cnt == CW'(DEBOUNCE_MS - 1)) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/time_edit_ctrl.sv
// Button-driven edit sequencer for the hh:mm:ss counter: edit FSM, inc/dec pulses,
// inactivity timeout and field blink. Optional auto-repeat: TIME_EDIT_AUTO_REPEAT_EN.
module time_edit_ctrl
  import time_edit_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_MS        = 250
`ifdef TIME_EDIT_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       freeze,
  output logic [1:0] sel,
  output logic       inc,
  output logic       dec,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  logic mode_lvl, mode_p, up_lvl, up_p, dn_lvl, dn_p;
  logic unused_lvl;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .raw(btn_mode), .level(mode_lvl), .press(mode_p));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_up (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .raw(btn_up), .level(up_lvl), .press(up_p));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_down (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .raw(btn_down), .level(dn_lvl), .press(dn_p));

  assign unused_lvl = &{1'b0, mode_lvl, up_lvl, dn_lvl};

  state_t        state, state_next;
  logic          inc_next, dec_next;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;
  logic          edit, timeout, any_press, hold_clear, rep_pulse, changing;

  assign edit      = (state != RUN);
  assign timeout   = edit && (to_cnt == TW'(TIMEOUT_MS));
  assign any_press = mode_p | up_p | dn_p;
  assign changing  = (state_next != state);

`ifdef TIME_EDIT_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_fast, hold_one;

  // Exactly one of UP/DOWN held; both held suppresses repeat.
  assign hold_one   = edit && (up_lvl ^ dn_lvl);
  assign hold_clear = up_lvl | dn_lvl;
  assign rep_pulse  = hold_one && tick_ms &&
                      (rep_fast ? (rep_cnt == RW'(REPEAT_RATE_MS - 1))
                                : (rep_cnt == RW'(REPEAT_DELAY_MS - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (!hold_one || up_p || dn_p || changing) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (tick_ms) begin
      if (rep_pulse) begin
        rep_cnt  <= '0;
        rep_fast <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end
`else
  assign hold_clear = 1'b0;
  assign rep_pulse  = 1'b0;
`endif

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    inc_next   = 1'b0;
    dec_next   = 1'b0;
    if (timeout) begin
      state_next = RUN;
    end else if (mode_p) begin
      case (state)
        RUN:     state_next = EDIT_HH;
        EDIT_HH: state_next = EDIT_MM;
        EDIT_MM: state_next = EDIT_SS;
        default: state_next = RUN;
      endcase
    end else if (edit) begin
      if (up_p && !dn_p) begin
        inc_next = 1'b1;
      end else if (dn_p && !up_p) begin
        dec_next = 1'b1;
      end else if (rep_pulse) begin
        inc_next = up_lvl;
        dec_next = dn_lvl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      freeze <= 1'b0;
      sel    <= SEL_NONE;
      inc    <= 1'b0;
      dec    <= 1'b0;
    end else begin
      state  <= state_next;
      freeze <= (state_next != RUN);
      sel    <= state_sel(state_next);
      inc    <= inc_next;
      dec    <= dec_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state_next == RUN || changing || any_press || hold_clear) begin
      to_cnt <= '0;
    end else if (tick_ms && !timeout) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Blink restarts its half-period high on state entry and on every inc/dec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (state_next == RUN) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (changing || inc_next || dec_next) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (tick_ms) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_time_edit_ctrl.sv
// Directed self-checking bench for time_edit_ctrl; tick_ms strobes every second clock.
module tb_time_edit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_ms = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       freeze, inc, dec, blink;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;
  int ticks = 0;
  int inc_cnt = 0, dec_cnt = 0, wide_cnt = 0, both_cnt = 0;
  int last_inc_tick = 0;
  int inc_ticks[$];
  logic inc_prev = 1'b0, dec_prev = 1'b0;

  time_edit_ctrl dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .freeze(freeze), .sel(sel), .inc(inc), .dec(dec), .blink(blink)
  );

  always #5 clk = ~clk;
  always @(negedge clk) tick_ms = ~tick_ms;
  always @(posedge clk) if (tick_ms) ticks <= ticks + 1;

  always @(negedge clk) begin
    if (inc) begin
      inc_cnt++;
      last_inc_tick = ticks;
      inc_ticks.push_back(ticks);
    end
    if (dec) dec_cnt++;
    if ((inc && inc_prev) || (dec && dec_prev)) wide_cnt++;
    if (inc && dec) both_cnt++;
    inc_prev = inc;
    dec_prev = dec;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick_ms);
    end
    #1;
  endtask

  task automatic wait_until_tick(input int target);
    for (int i = 0; i < 100000 && ticks < target; i++) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_up   = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    wait_ticks(30);
    set_btn(b, 1'b0);
    wait_ticks(30);
  endtask

  // Hold button b until sel reaches exp_sel (bounded); leaves the button held.
  task automatic enter_edge(input int b, input logic [1:0] exp_sel, input string tag);
    set_btn(b, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (sel === exp_sel) break;
    end
    check(tag, sel, exp_sel);
  endtask

  int base_i, base_d, t0, tp;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_freeze", freeze, 0);
    check("rst_sel", sel, 0);
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    check("rst_blink", blink, 0);
    rst = 1'b0;

    // MODE cycles through the edit fields and back to RUN
    press(0); check("m1_sel", sel, 3); check("m1_freeze", freeze, 1); check("m1_blink", blink, 1);
    press(0); check("m2_sel", sel, 2); check("m2_freeze", freeze, 1);
    press(0); check("m3_sel", sel, 1); check("m3_freeze", freeze, 1);
    press(0); check("m4_sel", sel, 0); check("m4_freeze", freeze, 0); check("m4_blink", blink, 0);

    // Blink half-period from entry into EDIT_HH
    enter_edge(0, 2'b11, "blink_entry");
    wait_ticks(30);
    btn_mode = 1'b0;
    wait_ticks(219);
    check("blink_249", blink, 1);
    wait_ticks(1);
    check("blink_250", blink, 0);
    wait_ticks(250);
    check("blink_500", blink, 1);

    // Bouncy UP in EDIT_MM: one inc, 20 ms after the input settles
    press(0); check("mm_sel", sel, 2);
    base_i = inc_cnt;
    repeat (3) begin
      btn_up = 1'b1; wait_ticks(5);
      btn_up = 1'b0; wait_ticks(5);
    end
    t0 = ticks;
    btn_up = 1'b1;
    wait_ticks(30);
    btn_up = 1'b0;
    wait_ticks(30);
    check("bounce_inc_count", inc_cnt - base_i, 1);
    check("bounce_latency", (last_inc_tick - t0 >= 20) && (last_inc_tick - t0 <= 22), 1);

    // DOWN in EDIT_SS gives one dec; UP in RUN is ignored
    press(0); check("ss_sel", sel, 1);
    base_i = inc_cnt; base_d = dec_cnt;
    press(2);
    check("ss_dec_count", dec_cnt - base_d, 1);
    check("ss_no_inc", inc_cnt - base_i, 0);
    check("ss_blink_forced", blink, 1);
    press(0); check("run_sel", sel, 0);
    base_i = inc_cnt;
    press(1);
    check("run_up_ignored", inc_cnt - base_i, 0);

    // MODE and UP together in EDIT_HH: MODE wins
    press(0); check("hh_sel", sel, 3);
    base_i = inc_cnt;
    btn_mode = 1'b1; btn_up = 1'b1;
    wait_ticks(30);
    btn_mode = 1'b0; btn_up = 1'b0;
    wait_ticks(30);
    check("mode_wins_sel", sel, 2);
    check("mode_wins_no_inc", inc_cnt - base_i, 0);

    // UP and DOWN together: neither pulses
    base_i = inc_cnt; base_d = dec_cnt;
    btn_up = 1'b1; btn_down = 1'b1;
    wait_ticks(30);
    btn_up = 1'b0; btn_down = 1'b0;
    wait_ticks(30);
    check("updn_no_inc", inc_cnt - base_i, 0);
    check("updn_no_dec", dec_cnt - base_d, 0);

    // Inactivity timeout from EDIT_HH
    press(0); press(0); check("to_pre_sel", sel, 0);
    enter_edge(0, 2'b11, "to_entry");
    wait_ticks(30);
    btn_mode = 1'b0;
    wait_ticks(9970);
    check("to_10000_still_frozen", freeze, 1);
    @(posedge clk); #1;
    check("to_freeze", freeze, 0);
    check("to_sel", sel, 0);
    check("to_blink", blink, 0);

    // A press late in the window restarts the timeout
    enter_edge(0, 2'b11, "rs_entry");
    wait_ticks(30);
    btn_mode = 1'b0;
    wait_ticks(9930);
    base_i = inc_cnt;
    btn_up = 1'b1;
    wait_ticks(30);
    btn_up = 1'b0;
    check("rs_inc", inc_cnt - base_i, 1);
    tp = last_inc_tick;
`ifdef TIME_EDIT_AUTO_REPEAT_EN
    wait_until_tick(tp + 10027);
    check("rs_hold", freeze, 1);
    wait_until_tick(tp + 10034);
    check("rs_timeout", freeze, 0);
`else
    wait_until_tick(tp + 9999);
    check("rs_hold", freeze, 1);
    wait_until_tick(tp + 10001);
    check("rs_timeout", freeze, 0);
`endif

    // Holding UP in EDIT_SS
    press(0); press(0); press(0); check("hold_sel", sel, 1);
    base_i = inc_cnt;
    btn_up = 1'b1;
    wait_ticks(1010);
    btn_up = 1'b0;
    wait_ticks(60);
`ifdef TIME_EDIT_AUTO_REPEAT_EN
    check("rep_count", inc_cnt - base_i, 7);
    check("rep_delay", inc_ticks[base_i + 1] - inc_ticks[base_i], 500);
    check("rep_span", inc_ticks[base_i + 6] - inc_ticks[base_i], 1000);
`else
    check("hold_single", inc_cnt - base_i, 1);
`endif

    // Reset mid-operation with MODE held through release
    btn_mode = 1'b1;
    wait_ticks(5);
    rst = 1'b1;
    wait_ticks(2);
    check("midrst_freeze", freeze, 0);
    check("midrst_sel", sel, 0);
    check("midrst_blink", blink, 0);
    rst = 1'b0;
    t0 = ticks;
    enter_edge(0, 2'b11, "held_through_rst");
    check("held_latency", (ticks - t0 >= 20) && (ticks - t0 <= 22), 1);
    btn_mode = 1'b0;
    wait_ticks(30);

    check("pulse_width", wide_cnt, 0);
    check("inc_dec_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
